ram_arbiter: RTL and testbench

// Shares the single SRAM driver (21-bit word address, base/ext bank select on bit 20) between
// the CPU data-memory port (port 0) and instruction-fetch port (port 1). Accepts one request at
// a time, sequences the driver's read/write handshake, returns read data with a one-cycle ack,
// and flags a hung transaction with a bus-error ack after a timeout.

---
 rtl/ram_arbiter.sv | 144 ++++++++++++++
 tb/tb_ram_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the single SRAM driver: grants one request at a time,
// sequences the driver handshake and times out hung transactions with an error ack.
module ram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter bit          PRIO_FIXED     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [20:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  output logic        p0_ack,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [20:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic        ram_enable,
  output logic        ram_read,
  output logic        ram_write,
  output logic [20:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_read_ready,
  input  logic        ram_write_finished
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RD, WR_ISSUE, WR_WAIT, REL} state_t;

  state_t        state_q, state_d;
  logic          port_q;
  logic          last_q;
  logic [20:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [TW-1:0] timer_q;

  logic        gnt_valid, gnt_port, gnt_we;
  logic [20:0] gnt_addr;
  logic [31:0] gnt_wdata;
  logic        rd_done, wr_done, timed_out, fin, busy_d;

  logic        nx_enable, nx_read, nx_write;
  logic [20:0] nx_addr;
  logic [31:0] nx_wdata;
  logic        nx_p0_ack, nx_p1_ack, nx_p0_err, nx_p1_err;

  assign gnt_valid = p0_req | p1_req;
  assign gnt_port  = (p0_req && p1_req) ? (PRIO_FIXED ? 1'b0 : ~last_q) : p1_req;
  assign gnt_we    = gnt_port ? p1_we    : p0_we;
  assign gnt_addr  = gnt_port ? p1_addr  : p0_addr;
  assign gnt_wdata = gnt_port ? p1_wdata : p0_wdata;

  // A real completion in the same cycle as the timer expiring wins over the timeout.
  assign rd_done   = (state_q == RD) && ram_read_ready;
  assign wr_done   = (state_q == WR_WAIT) && ram_write_finished;
  assign timed_out = ((state_q == RD) || (state_q == WR_WAIT)) && !rd_done && !wr_done &&
                     (timer_q == TIMER_MAX);
  assign fin       = rd_done | wr_done | timed_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      port_q     <= 1'b0;
      last_q     <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      timer_q    <= '0;
      ram_enable <= 1'b0;
      ram_read   <= 1'b0;
      ram_write  <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_err     <= 1'b0;
      p1_err     <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      state_q    <= state_d;
      ram_enable <= nx_enable;
      ram_read   <= nx_read;
      ram_write  <= nx_write;
      ram_addr   <= nx_addr;
      ram_wdata  <= nx_wdata;
      p0_ack     <= nx_p0_ack;
      p1_ack     <= nx_p1_ack;
      p0_err     <= nx_p0_err;
      p1_err     <= nx_p1_err;
      if (state_q == IDLE && gnt_valid) begin
        port_q  <= gnt_port;
        last_q  <= gnt_port;
        addr_q  <= gnt_addr;
        wdata_q <= gnt_wdata;
        timer_q <= '0;
      end else if (((state_q == RD) || (state_q == WR_WAIT)) && (timer_q != TIMER_MAX)) begin
        timer_q <= timer_q + TW'(1);
      end
      if (rd_done) begin
        if (port_q) p1_rdata <= ram_rdata;
        else        p0_rdata <= ram_rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (gnt_valid) state_d = gnt_we ? WR_ISSUE : RD;
      RD:       if (rd_done || timed_out) state_d = REL;
      WR_ISSUE: state_d = WR_WAIT;
      WR_WAIT:  if (wr_done || timed_out) state_d = REL;
      REL:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are registered, so these are the values they take after the coming edge.
  always_comb begin
    busy_d    = (state_d == RD) || (state_d == WR_ISSUE) || (state_d == WR_WAIT);
    nx_enable = busy_d;
    nx_read   = (state_d == RD);
    nx_write  = (state_d == WR_ISSUE);
    nx_addr   = '0;
    nx_wdata  = '0;
    if (busy_d) begin
      nx_addr  = (state_q == IDLE) ? gnt_addr  : addr_q;
      nx_wdata = (state_q == IDLE) ? gnt_wdata : wdata_q;
    end
    nx_p0_ack = fin && !port_q;
    nx_p1_ack = fin && port_q;
    nx_p0_err = timed_out && !port_q;
    nx_p1_err = timed_out && port_q;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: driver/RAM model plus a transaction-level reference of grants,
// memory contents, returned data and handshake timing.
module tb_ram_arbiter;

  localparam int unsigned TO     = 16;
  localparam int unsigned RD_LAT = 5;
  localparam int unsigned WR_LAT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        p0_req, p0_we, p0_ack, p0_err, p1_req, p1_we, p1_ack, p1_err;
  logic [20:0] p0_addr, p1_addr, ram_addr;
  logic [31:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, ram_wdata, ram_rdata;
  logic        ram_enable, ram_read, ram_write, ram_read_ready, ram_write_finished;

  logic        fx_p0_req, fx_p1_req, fx_p0_ack, fx_p1_ack, fx_p0_err, fx_p1_err;
  logic [20:0] fx_p0_addr, fx_p1_addr, fx_ram_addr;
  logic [31:0] fx_p0_rdata, fx_p1_rdata, fx_ram_wdata, fx_ram_rdata;
  logic        fx_ram_enable, fx_ram_read, fx_ram_write, fx_ram_read_ready;

  ram_arbiter #(.TIMEOUT_CYCLES(TO), .PRIO_FIXED(1'b0)) u_rr (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ack(p1_ack), .p1_err(p1_err),
    .ram_enable(ram_enable), .ram_read(ram_read), .ram_write(ram_write),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_read_ready(ram_read_ready), .ram_write_finished(ram_write_finished)
  );

  ram_arbiter #(.TIMEOUT_CYCLES(TO), .PRIO_FIXED(1'b1)) u_fx (
    .clk(clk), .rst(rst),
    .p0_req(fx_p0_req), .p0_we(1'b0), .p0_addr(fx_p0_addr), .p0_wdata(32'h0),
    .p0_rdata(fx_p0_rdata), .p0_ack(fx_p0_ack), .p0_err(fx_p0_err),
    .p1_req(fx_p1_req), .p1_we(1'b0), .p1_addr(fx_p1_addr), .p1_wdata(32'h0),
    .p1_rdata(fx_p1_rdata), .p1_ack(fx_p1_ack), .p1_err(fx_p1_err),
    .ram_enable(fx_ram_enable), .ram_read(fx_ram_read), .ram_write(fx_ram_write),
    .ram_addr(fx_ram_addr), .ram_wdata(fx_ram_wdata), .ram_rdata(fx_ram_rdata),
    .ram_read_ready(fx_ram_read_ready), .ram_write_finished(1'b0)
  );

  // Initial RAM contents: a known word at 0x10, otherwise a pattern derived from the address.
  function automatic logic [31:0] ram_init(input logic [20:0] a);
    return (a == 21'h000010) ? 32'hDEADBEEF : {11'h5A5, a};
  endfunction

  // SRAM driver model: tagged storage so any address bit error is visible on readback.
  logic [31:0] ram_mem [256];
  logic [20:0] ram_tag [256];
  logic        ram_vld [256];
  logic [3:0]  rcnt, wcnt, fx_rcnt;
  logic        hang, mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) ram_vld[i] <= 1'b0;
      rcnt <= '0;
      wcnt <= '0;
    end else begin
      rcnt <= ram_read ? ((rcnt == 4'hF) ? rcnt : rcnt + 4'd1) : 4'd0;
      if (ram_write) begin
        ram_mem[ram_addr[7:0]] <= ram_wdata;
        ram_tag[ram_addr[7:0]] <= ram_addr;
        ram_vld[ram_addr[7:0]] <= 1'b1;
        wcnt <= 4'd1;
      end else if (wcnt != 4'd0) begin
        wcnt <= (wcnt == 4'(WR_LAT)) ? 4'd0 : wcnt + 4'd1;
      end
    end
    fx_rcnt <= (fx_ram_read && !mem_clr) ? ((fx_rcnt == 4'hF) ? fx_rcnt : fx_rcnt + 4'd1) : 4'd0;
  end

  assign ram_read_ready     = ram_read && !hang && (rcnt >= 4'(RD_LAT));
  assign ram_write_finished = (wcnt == 4'(WR_LAT));
  assign ram_rdata = (ram_vld[ram_addr[7:0]] && ram_tag[ram_addr[7:0]] == ram_addr) ?
                     ram_mem[ram_addr[7:0]] : ram_init(ram_addr);
  assign fx_ram_read_ready  = fx_ram_read && (fx_rcnt >= 4'(RD_LAT));
  assign fx_ram_rdata       = 32'hF000_0000 | {11'h0, fx_ram_addr};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: memory contents, last returned data per port, round-robin preference.
  logic [31:0] ref_mem [int];
  logic [31:0] exp_rd [2];
  int          last_port;

  function automatic logic [31:0] ref_read(input logic [20:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : ram_init(a);
  endfunction

  function automatic logic [20:0] addr_of(input int k);
    logic [20:0] a;
    a[20]   = k[0];
    a[19:8] = 12'(k * 291);
    a[7:0]  = 8'(k * 16 + 3);
    return a;
  endfunction

  int   cyc = 0, rise_cyc = 0, wr_run = 0, last_wr_run = 0;
  logic en_prev = 1'b0;

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (ram_enable && !en_prev) rise_cyc = cyc;
    en_prev = ram_enable;
    if (ram_write) wr_run++;
    else if (wr_run != 0) begin
      last_wr_run = wr_run;
      wr_run = 0;
    end
  endtask

  task automatic run_pair(input bit u0, input bit u1, input bit we0, input bit we1,
                          input logic [20:0] a0, input logic [20:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1, input bit drop_early);
    bit done [2];
    int first, port, n_acks;
    bit we;
    logic [20:0] a;
    logic [31:0] d;
    first  = (u0 && u1) ? 1 - last_port : (u0 ? 0 : 1);
    n_acks = 0;
    done[0] = !u0;
    done[1] = !u1;
    p0_req = u0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
    p1_req = u1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
    for (int b = 0; b < 200 && !(done[0] && done[1]); b++) begin
      tick();
      if (drop_early && ram_enable && cyc == rise_cyc + 1) p0_req = 1'b0;
      if (p0_ack || p1_ack) begin
        check("ack_exclusive", {p0_ack, p1_ack} == 2'b11, 1'b0);
        port = p1_ack ? 1 : 0;
        check("ack_unexpected", done[port], 1'b0);
        check("ack_order", port, (n_acks == 0) ? first : 1 - first);
        we = port ? we1 : we0;
        a  = port ? a1 : a0;
        d  = port ? d1 : d0;
        check("err_flag", port ? p1_err : p0_err, hang && !we);
        check("err_other", port ? p0_err : p1_err, 1'b0);
        if (!we && !hang) exp_rd[port] = ref_read(a);
        if (we) ref_mem[int'(a)] = d;
        check("rdata", port ? p1_rdata : p0_rdata, exp_rd[port]);
        check("rdata_other", port ? p0_rdata : p1_rdata, exp_rd[1 - port]);
        check("latency", cyc - rise_cyc, hang ? TO : (we ? WR_LAT + 1 : RD_LAT + 1));
        if (we) check("wr_pulse_len", last_wr_run, 1);
        check("ram_idle_after_ack", {ram_enable, ram_read, ram_write, ram_addr, ram_wdata}, '0);
        if (port == 1) p1_req = 1'b0;
        else           p0_req = 1'b0;
        done[port] = 1'b1;
        last_port  = port;
        n_acks++;
      end else begin
        check("err_without_ack", {p0_err, p1_err}, 2'b00);
      end
    end
    check("all_acked", {done[0], done[1]}, 2'b11);
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (3) begin
      tick();
      check("no_extra_ack", {p0_ack, p1_ack}, 2'b00);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0, cnt1, kind, k0, k1;
    rst = 1'b1; mem_clr = 1'b1; hang = 1'b0; last_port = 1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    fx_p0_req = 0; fx_p1_req = 0; fx_p0_addr = 21'h000123; fx_p1_addr = 21'h100456;
    repeat (3) tick();
    check("reset_ctrl", {p0_ack, p1_ack, p0_err, p1_err, ram_enable, ram_read, ram_write}, '0);
    check("reset_bus", {ram_addr, ram_wdata}, '0);
    check("reset_rdata", {p0_rdata, p1_rdata}, '0);
    rst = 1'b0; mem_clr = 1'b0;
    repeat (2) tick();

    run_pair(0, 1, 0, 0, '0, 21'h000010, '0, '0, 0);
    check("p1_deadbeef", p1_rdata, 32'hDEADBEEF);
    run_pair(1, 0, 1, 0, 21'h100004, '0, 32'h12345678, '0, 0);
    run_pair(0, 1, 0, 0, '0, 21'h100004, '0, '0, 0);
    check("p1_readback", p1_rdata, 32'h12345678);

    for (int i = 0; i < 4; i++) run_pair(1, 1, 0, 0, addr_of(i), addr_of(i + 4), '0, '0, 0);

    // Fixed-priority instance with both ports requesting continuously.
    cnt0 = 0; cnt1 = 0;
    fx_p0_req = 1'b1; fx_p1_req = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (fx_p0_ack) begin
        cnt0++;
        check("fx_rdata", fx_p0_rdata, 32'hF000_0000 | {11'h0, fx_p0_addr});
      end
      if (fx_p1_ack) cnt1++;
      check("fx_err", {fx_p0_err, fx_p1_err}, 2'b00);
      check("fx_no_write", {fx_ram_write, fx_ram_wdata}, '0);
    end
    fx_p0_req = 1'b0; fx_p1_req = 1'b0;
    check("fx_p1_starved", cnt1, 0);
    check("fx_p0_served", cnt0 >= 8, 1'b1);
    check("fx_p1_rdata", fx_p1_rdata, '0);

    hang = 1'b1;
    run_pair(1, 0, 0, 0, addr_of(9), '0, '0, '0, 0);
    hang = 1'b0;
    run_pair(1, 0, 0, 0, addr_of(9), '0, '0, '0, 0);

    run_pair(1, 0, 0, 0, addr_of(2), '0, '0, '0, 1);
    run_pair(1, 0, 1, 0, addr_of(3), '0, 32'hCAFE0003, '0, 1);

    // Reset while a read is outstanding.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = addr_of(5);
    for (int b = 0; b < 10 && !ram_read; b++) tick();
    tick();
    #2 rst = 1'b1;
    #1 check("rst_async", {ram_enable, ram_read}, 2'b00);
    p0_req = 1'b0;
    repeat (3) begin
      tick();
      check("rst_no_ack", {p0_ack, p1_ack}, 2'b00);
    end
    rst = 1'b0;
    last_port = 1; exp_rd[0] = '0; exp_rd[1] = '0;
    check("rst_rdata", {p0_rdata, p1_rdata}, '0);
    repeat (8) begin
      tick();
      check("rst_aborted", {p0_ack, p1_ack, ram_enable}, 3'b000);
    end
    run_pair(1, 0, 0, 0, addr_of(5), '0, '0, '0, 0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      k0 = $urandom_range(0, 15);
      k1 = $urandom_range(0, 15);
      run_pair(kind != 1, kind != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               addr_of(k0), addr_of(k1), $urandom, $urandom, 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
